// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
//   Parametrised N-channel, W-bit registered channel selector with an
//   auto-scan mode. In manual mode the channel follows 'sel'. In scan mode the
//   active channel advances by one every DIV clocks, wrapping from N-1 to 0.
//   A one-hot LED bus shows the active channel. Its top bit shows that the
//   block is scanning or holding.
//
// Parameters
//   W     data width per channel
//   N     channel count (power of 2, 2..16)
//   SW    select width, derived from N
//   DIV   clock cycles per scan step (>= 2)
//   LEDW  LED bus width (>= N+1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-low
//   in       in   packed channels, channel k = in[k*W +: W]
//   sel      in   manual channel select
//   mode     in   0 = manual, 1 = auto-scan
//   hold     in   freeze stepping while in scan mode
//   y        out  registered data of the active channel
//   cur_sel  out  registered active channel index
//   tick     out  one-cycle pulse on each scan step
//   led      out  registered one-hot channel indicator, MSB = scanning
// -----------------------------------------------------------------------------
module scan_mux #(
    parameter int W    = 1,
    parameter int N    = 4,
    parameter int SW   = $clog2(N),
    parameter int DIV  = 5000000,
    parameter int LEDW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in,
    input  logic [SW-1:0]     sel,
    input  logic              mode,
    input  logic              hold,
    output logic [W-1:0]      y,
    output logic [SW-1:0]     cur_sel,
    output logic              tick,
    output logic [LEDW-1:0]   led
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] SEL_LAST   = SW'(N - 1);

    localparam logic [1:0] MANUAL = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]      state_reg,   state_next;
    logic [CW-1:0]   count_reg,   count_next;
    logic [SW-1:0]   cur_sel_reg, cur_sel_next;
    logic            tick_reg,    tick_next;
    logic [W-1:0]    y_reg,       y_next;
    logic [LEDW-1:0] led_reg,     led_next;
    logic            scan_active;

    logic [W-1:0]    chan [N];

    // Transitions depend only on the mode and hold inputs.
    always_comb begin
        state_next = MANUAL;
        if (mode) begin
            state_next = hold ? HOLD : SCAN;
        end
    end

    assign scan_active = (state_next == SCAN) || (state_next == HOLD);

    // Apply the action of the state that this edge enters.
    always_comb begin
        count_next   = count_reg;
        cur_sel_next = cur_sel_reg;
        tick_next    = 1'b0;
        case (state_next)
            SCAN: begin
                if (state_reg == MANUAL) begin
                    // On the entry edge the count is loaded with 0, so the
                    // first step comes a full DIV cycles after entry.
                    count_next = '0;
                end else if (count_reg == COUNT_LAST) begin
                    count_next   = '0;
                    tick_next    = 1'b1;
                    cur_sel_next = (cur_sel_reg == SEL_LAST) ? '0
                                                             : cur_sel_reg + SW'(1);
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            HOLD: begin
                // Count and channel stay frozen. When this state is entered
                // from MANUAL, the count is already 0.
            end
            default: begin
                cur_sel_next = sel;
                count_next   = '0;
            end
        endcase
    end

    // Split the packed input bus into channels. The data mux uses the next
    // index, so y always agrees with cur_sel in the same cycle.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan[gi] = in[gi*W +: W];
        end
    endgenerate

    assign y_next = chan[cur_sel_next];

    // LED bus: one-hot channel in the low N bits, scan flag in the MSB.
    generate
        for (genvar gi = 0; gi < LEDW; gi++) begin : g_led
            if (gi < N) begin : g_onehot
                assign led_next[gi] = (cur_sel_next == SW'(gi));
            end else if (gi == LEDW - 1) begin : g_flag
                assign led_next[gi] = scan_active;
            end else begin : g_zero
                assign led_next[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= MANUAL;
            count_reg   <= '0;
            cur_sel_reg <= '0;
            tick_reg    <= 1'b0;
            y_reg       <= '0;
            led_reg     <= LEDW'(1);
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            cur_sel_reg <= cur_sel_next;
            tick_reg    <= tick_next;
            y_reg       <= y_next;
            led_reg     <= led_next;
        end
    end

    assign y       = y_reg;
    assign cur_sel = cur_sel_reg;
    assign tick    = tick_reg;
    assign led     = led_reg;

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int SW   = 2;
    localparam int DIV  = 4;
    localparam int LEDW = 16;

    logic            clk;
    logic            rst;
    logic [N*W-1:0]  in;
    logic [SW-1:0]   sel;
    logic            mode;
    logic            hold;
    logic [W-1:0]    y;
    logic [SW-1:0]   cur_sel;
    logic            tick;
    logic [LEDW-1:0] led;

    int n_checks;
    int n_pass;

    logic [7:0] chan_val [4];

    scan_mux #(
        .W    (W),
        .N    (N),
        .DIV  (DIV),
        .LEDW (LEDW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .sel     (sel),
        .mode    (mode),
        .hold    (hold),
        .y       (y),
        .cur_sel (cur_sel),
        .tick    (tick),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end else begin
            n_pass++;
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one rising edge and sample 1 ns after it.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_led(input int ch, input bit scanning);
        logic [15:0] v;
        v = 16'h0001 << ch;
        if (scanning) v = v | 16'h8000;
        return v;
    endfunction

    // Check all four outputs against the expected channel and flags.
    task automatic chk_all(input string tag, input int ch, input bit exp_tick, input bit scanning);
        chk({tag, ".tick"},    32'(tick),    32'(exp_tick));
        chk({tag, ".cur_sel"}, 32'(cur_sel), 32'(ch));
        chk({tag, ".y"},       32'(y),       32'(chan_val[ch]));
        chk({tag, ".led"},     32'(led),     32'(exp_led(ch, scanning)));
    endtask

    initial begin
        int exp_cur;
        bit exp_tick;

        n_checks = 0;
        n_pass   = 0;
        chan_val[0] = 8'hAA;
        chan_val[1] = 8'hBB;
        chan_val[2] = 8'hCC;
        chan_val[3] = 8'hDD;
        in   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        rst  = 1'b0;
        mode = 1'b1;
        sel  = 2'd2;
        hold = 1'b0;

        // Reset held for 3 edges with mode=1 and sel=2.
        repeat (3) edge1();
        chk("rst.y",       32'(y),       32'h0);
        chk("rst.cur_sel", 32'(cur_sel), 32'h0);
        chk("rst.tick",    32'(tick),    32'h0);
        chk("rst.led",     32'(led),     32'h0001);

        // Release reset: SCAN entered with count 0, so the first tick comes on the 5th edge.
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk_all($sformatf("rel%0d", k), 0, 1'b0, 1'b1);
        end
        edge1();
        chk_all("rel5", 1, 1'b1, 1'b1);

        // Manual select: sel 0..3, one cycle latency each.
        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = SW'(s);
            edge1();
            chk_all($sformatf("man%0d", s), s, 1'b0, 1'b0);
        end
        // An input change appears on y one edge later.
        in[31:24] = 8'hEE;
        edge1();
        chk("man.in_chg.y", 32'(y), 32'hEE);
        in[31:24] = 8'hDD;

        // Scan from channel 2: the sequence is 2,3,0,1,2 with a tick every 4 edges.
        sel = 2'd2;
        edge1();
        chk_all("scan.pre", 2, 1'b0, 1'b0);
        mode    = 1'b1;
        sel     = 2'd0;
        exp_cur = 2;
        for (int k = 1; k <= 17; k++) begin
            exp_tick = (k >= 5) && (((k - 5) % 4) == 0);
            if (exp_tick) exp_cur = (exp_cur + 1) % 4;
            edge1();
            chk_all($sformatf("scan%0d", k), exp_cur, exp_tick, 1'b1);
        end

        // Hold at count=2 for 10 edges.
        repeat (2) edge1();
        hold = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            edge1();
            chk_all($sformatf("hold%0d", k), 2, 1'b0, 1'b1);
        end
        hold = 1'b0;
        edge1();
        chk_all("unhold1", 2, 1'b0, 1'b1);
        edge1();
        chk_all("unhold2", 3, 1'b1, 1'b1);

        // Mode switch exactly when a step is due.
        repeat (3) edge1();
        mode = 1'b0;
        sel  = 2'd1;
        edge1();
        chk_all("msw", 1, 1'b0, 1'b0);
        chk("msw.led15", 32'(led[15]), 32'h0);
        mode = 1'b1;
        sel  = 2'd3;
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk_all($sformatf("resc%0d", k), 1, 1'b0, 1'b1);
        end
        edge1();
        chk_all("resc5", 2, 1'b1, 1'b1);

        // Assert reset on the edge where a tick is due. Outputs must not change before that edge.
        repeat (3) edge1();
        rst = 1'b0;
        #3;
        chk("srst.pre.cur_sel", 32'(cur_sel), 32'h2);
        chk("srst.pre.led",     32'(led),     32'h8004);
        edge1();
        chk("srst.tick",    32'(tick),    32'h0);
        chk("srst.cur_sel", 32'(cur_sel), 32'h0);
        chk("srst.y",       32'(y),       32'h0);
        chk("srst.led",     32'(led),     32'h0001);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk_all($sformatf("post%0d", k), 0, 1'b0, 1'b1);
        end
        edge1();
        chk_all("post5", 1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
